// File: rtl/llc_buf_fill_pkg.sv
// Shared LLC field widths, per-way typedefs and the buffer-fill sequencer state encoding.
package llc_buf_fill_pkg;

   localparam int LLC_WAYS         = 16;
   localparam int LLC_RD_LAT       = 1;
   localparam int LLC_LINE_BITS    = 128;
   localparam int LLC_TAG_BITS     = 20;
   localparam int LLC_STATE_BITS   = 3;
   localparam int LLC_OWNER_BITS   = 4;
   localparam int LLC_SHARERS_BITS = 16;
   localparam int LLC_HPROT_BITS   = 1;
   localparam int LLC_WAY_BITS     = $clog2(LLC_WAYS);

   typedef logic [LLC_LINE_BITS-1:0]    line_t;
   typedef logic [LLC_TAG_BITS-1:0]     llc_tag_t;
   typedef logic [LLC_STATE_BITS-1:0]   llc_state_t;
   typedef logic [LLC_OWNER_BITS-1:0]   owner_t;
   typedef logic [LLC_SHARERS_BITS-1:0] sharers_t;
   typedef logic [LLC_HPROT_BITS-1:0]   hprot_t;
   typedef logic [LLC_WAY_BITS-1:0]     llc_way_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      FILL,
      PUSH
   } llc_fill_state_t;

endpackage

// File: rtl/llc_fill_way_mux.sv
// Combinational selector picking one way's fields out of the flattened local-memory read arrays.
module llc_fill_way_mux
   import llc_buf_fill_pkg::*;
#(
   parameter int WAYS         = LLC_WAYS,
   parameter int LINE_BITS    = LLC_LINE_BITS,
   parameter int TAG_BITS     = LLC_TAG_BITS,
   parameter int STATE_BITS   = LLC_STATE_BITS,
   parameter int OWNER_BITS   = LLC_OWNER_BITS,
   parameter int SHARERS_BITS = LLC_SHARERS_BITS,
   parameter int HPROT_BITS   = LLC_HPROT_BITS
)(
   input  logic [$clog2(WAYS)-1:0]        way,
   input  logic [WAYS*LINE_BITS-1:0]      rd_line,
   input  logic [WAYS*TAG_BITS-1:0]       rd_tag,
   input  logic [WAYS*STATE_BITS-1:0]     rd_state,
   input  logic [WAYS*OWNER_BITS-1:0]     rd_owner,
   input  logic [WAYS*SHARERS_BITS-1:0]   rd_sharers,
   input  logic [WAYS*HPROT_BITS-1:0]     rd_hprot,
   input  logic [WAYS-1:0]                rd_dirty,
   output logic [LINE_BITS-1:0]           sel_line,
   output logic [TAG_BITS-1:0]            sel_tag,
   output logic [STATE_BITS-1:0]          sel_state,
   output logic [OWNER_BITS-1:0]          sel_owner,
   output logic [SHARERS_BITS-1:0]        sel_sharers,
   output logic [HPROT_BITS-1:0]          sel_hprot,
   output logic                           sel_dirty
);

   always_comb begin
      sel_line    = rd_line[int'(way)*LINE_BITS +: LINE_BITS];
      sel_tag     = rd_tag[int'(way)*TAG_BITS +: TAG_BITS];
      sel_state   = rd_state[int'(way)*STATE_BITS +: STATE_BITS];
      sel_owner   = rd_owner[int'(way)*OWNER_BITS +: OWNER_BITS];
      sel_sharers = rd_sharers[int'(way)*SHARERS_BITS +: SHARERS_BITS];
      sel_hprot   = rd_hprot[int'(way)*HPROT_BITS +: HPROT_BITS];
      sel_dirty   = rd_dirty[way];
   end

endmodule

// File: rtl/llc_buf_fill.sv
// LLC set-buffer fill sequencer: pop request, read set, stream ways into buffers, push downstream.
// Defining LLC_BUF_FILL_STATS_EN adds the saturating fill_count port.
module llc_buf_fill
   import llc_buf_fill_pkg::*;
#(
   parameter int WAYS         = LLC_WAYS,
   parameter int RD_LAT       = LLC_RD_LAT,
   parameter int LINE_BITS    = LLC_LINE_BITS,
   parameter int TAG_BITS     = LLC_TAG_BITS,
   parameter int STATE_BITS   = LLC_STATE_BITS,
   parameter int OWNER_BITS   = LLC_OWNER_BITS,
   parameter int SHARERS_BITS = LLC_SHARERS_BITS,
   parameter int HPROT_BITS   = LLC_HPROT_BITS
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rst_state,
   input  logic                           mem_empty,
   input  logic                           mem_look,
   output logic                           mem_pop,
   output logic                           rd_mem_en,
   input  logic [WAYS*LINE_BITS-1:0]      rd_line,
   input  logic [WAYS*TAG_BITS-1:0]       rd_tag,
   input  logic [WAYS*STATE_BITS-1:0]     rd_state,
   input  logic [WAYS*OWNER_BITS-1:0]     rd_owner,
   input  logic [WAYS*SHARERS_BITS-1:0]   rd_sharers,
   input  logic [WAYS*HPROT_BITS-1:0]     rd_hprot,
   input  logic [WAYS-1:0]                rd_dirty,
   input  logic [$clog2(WAYS)-1:0]        rd_evict_way,
   output logic                           buf_wr_en,
   output logic [$clog2(WAYS)-1:0]        buf_way,
   output logic [LINE_BITS-1:0]           buf_line,
   output logic [TAG_BITS-1:0]            buf_tag,
   output logic [STATE_BITS-1:0]          buf_state,
   output logic [OWNER_BITS-1:0]          buf_owner,
   output logic [SHARERS_BITS-1:0]        buf_sharers,
   output logic [HPROT_BITS-1:0]          buf_hprot,
   output logic                           buf_dirty,
   output logic                           evict_ld,
   output logic [$clog2(WAYS)-1:0]        evict_val,
   input  logic                           full_lookup,
   input  logic                           full_proc,
   output logic                           push_lookup,
   output logic                           push_proc,
   output logic                           busy
`ifdef LLC_BUF_FILL_STATS_EN
   ,
   output logic [15:0]                    fill_count
`endif
);

   localparam int WAY_W = $clog2(WAYS);
   localparam int LAT_W = $clog2(RD_LAT + 1);

   llc_fill_state_t      state, state_nxt;
   logic [WAY_W-1:0]     way_cnt, way_nxt;
   logic [LAT_W-1:0]     lat_cnt, lat_nxt;
   logic                 pop_c, rd_c, push_c;
   logic                 wr_nxt, ev_nxt;

   logic [LINE_BITS-1:0]    sel_line;
   logic [TAG_BITS-1:0]     sel_tag;
   logic [STATE_BITS-1:0]   sel_state;
   logic [OWNER_BITS-1:0]   sel_owner;
   logic [SHARERS_BITS-1:0] sel_sharers;
   logic [HPROT_BITS-1:0]   sel_hprot;
   logic                    sel_dirty;

   // Selection uses the upcoming way so the buffer fields come out of a register in the FILL cycle.
   llc_fill_way_mux #(
      .WAYS(WAYS), .LINE_BITS(LINE_BITS), .TAG_BITS(TAG_BITS), .STATE_BITS(STATE_BITS),
      .OWNER_BITS(OWNER_BITS), .SHARERS_BITS(SHARERS_BITS), .HPROT_BITS(HPROT_BITS)
   ) u_way_mux (
      .way(way_nxt), .rd_line(rd_line), .rd_tag(rd_tag), .rd_state(rd_state),
      .rd_owner(rd_owner), .rd_sharers(rd_sharers), .rd_hprot(rd_hprot), .rd_dirty(rd_dirty),
      .sel_line(sel_line), .sel_tag(sel_tag), .sel_state(sel_state), .sel_owner(sel_owner),
      .sel_sharers(sel_sharers), .sel_hprot(sel_hprot), .sel_dirty(sel_dirty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         way_cnt <= '0;
         lat_cnt <= '0;
      end else begin
         state   <= state_nxt;
         way_cnt <= way_nxt;
         lat_cnt <= lat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      way_nxt   = way_cnt;
      lat_nxt   = lat_cnt;
      pop_c     = 1'b0;
      rd_c      = 1'b0;
      push_c    = 1'b0;
      case (state)
         IDLE: begin
            if (!mem_empty) begin
               pop_c = 1'b1;
               if (mem_look) begin
                  rd_c      = 1'b1;
                  lat_nxt   = '0;
                  state_nxt = RD_WAIT;
               end else begin
                  state_nxt = PUSH;
               end
            end
         end
         RD_WAIT: begin
            lat_nxt = lat_cnt + 1'b1;
            if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
               way_nxt   = '0;
               state_nxt = FILL;
            end
         end
         FILL: begin
            way_nxt = way_cnt + 1'b1;
            if (way_cnt == WAY_W'(WAYS - 1))
               state_nxt = PUSH;
         end
         PUSH: begin
            if (!full_lookup && !full_proc) begin
               push_c    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Abort discards the in-flight packet and also blocks a pop in the same cycle.
      if (rst_state || !rst) begin
         state_nxt = IDLE;
         way_nxt   = '0;
         lat_nxt   = '0;
         pop_c     = 1'b0;
         rd_c      = 1'b0;
         push_c    = 1'b0;
      end
   end

   assign wr_nxt      = (state_nxt == FILL);
   assign ev_nxt      = wr_nxt && (way_nxt == WAY_W'(WAYS - 1));
   assign mem_pop     = pop_c;
   assign rd_mem_en   = rd_c;
   assign push_lookup = push_c;
   assign push_proc   = push_c;
   assign busy        = (state != IDLE);
   assign buf_way     = way_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_wr_en   <= 1'b0;
         buf_line    <= '0;
         buf_tag     <= '0;
         buf_state   <= '0;
         buf_owner   <= '0;
         buf_sharers <= '0;
         buf_hprot   <= '0;
         buf_dirty   <= 1'b0;
         evict_ld    <= 1'b0;
         evict_val   <= '0;
      end else begin
         buf_wr_en   <= wr_nxt;
         buf_line    <= wr_nxt ? sel_line    : '0;
         buf_tag     <= wr_nxt ? sel_tag     : '0;
         buf_state   <= wr_nxt ? sel_state   : '0;
         buf_owner   <= wr_nxt ? sel_owner   : '0;
         buf_sharers <= wr_nxt ? sel_sharers : '0;
         buf_hprot   <= wr_nxt ? sel_hprot   : '0;
         buf_dirty   <= wr_nxt & sel_dirty;
         evict_ld    <= ev_nxt;
         evict_val   <= ev_nxt ? rd_evict_way : '0;
      end
   end

`ifdef LLC_BUF_FILL_STATS_EN
   logic look_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         look_q     <= 1'b0;
         fill_count <= '0;
      end else begin
         if (pop_c)
            look_q <= mem_look;
         if (rst_state)
            fill_count <= '0;
         else if (push_c && look_q && fill_count != 16'hFFFF)
            fill_count <= fill_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_llc_buf_fill.sv
// Scoreboard bench for llc_buf_fill (WAYS=4, RD_LAT=2) driven from a per-cycle directed timeline.
`timescale 1ns/1ps
module tb_llc_buf_fill;

   localparam int WAYS = 4;
   localparam int RD_LAT = 2;
   localparam int LB = 128;
   localparam int TB = 20;
   localparam int SB = 3;
   localparam int OB = 4;
   localparam int SHB = 16;
   localparam int HB = 1;

   logic clk = 1'b0;
   logic rst, rst_state, mem_empty, mem_look, full_lookup, full_proc;
   logic mem_pop, rd_mem_en, buf_wr_en, evict_ld, push_lookup, push_proc, busy, buf_dirty;
   logic [WAYS*LB-1:0]  rd_line;
   logic [WAYS*TB-1:0]  rd_tag;
   logic [WAYS*SB-1:0]  rd_state;
   logic [WAYS*OB-1:0]  rd_owner;
   logic [WAYS*SHB-1:0] rd_sharers;
   logic [WAYS*HB-1:0]  rd_hprot;
   logic [WAYS-1:0]     rd_dirty;
   logic [1:0]          rd_evict_way, buf_way, evict_val;
   logic [LB-1:0]       buf_line;
   logic [TB-1:0]       buf_tag;
   logic [SB-1:0]       buf_state;
   logic [OB-1:0]       buf_owner;
   logic [SHB-1:0]      buf_sharers;
   logic [HB-1:0]       buf_hprot;
`ifdef LLC_BUF_FILL_STATS_EN
   logic [15:0]         fill_count;
`endif

   llc_buf_fill #(
      .WAYS(WAYS), .RD_LAT(RD_LAT), .LINE_BITS(LB), .TAG_BITS(TB), .STATE_BITS(SB),
      .OWNER_BITS(OB), .SHARERS_BITS(SHB), .HPROT_BITS(HB)
   ) dut (
      .clk(clk), .rst(rst), .rst_state(rst_state), .mem_empty(mem_empty), .mem_look(mem_look),
      .mem_pop(mem_pop), .rd_mem_en(rd_mem_en), .rd_line(rd_line), .rd_tag(rd_tag),
      .rd_state(rd_state), .rd_owner(rd_owner), .rd_sharers(rd_sharers), .rd_hprot(rd_hprot),
      .rd_dirty(rd_dirty), .rd_evict_way(rd_evict_way), .buf_wr_en(buf_wr_en), .buf_way(buf_way),
      .buf_line(buf_line), .buf_tag(buf_tag), .buf_state(buf_state), .buf_owner(buf_owner),
      .buf_sharers(buf_sharers), .buf_hprot(buf_hprot), .buf_dirty(buf_dirty),
      .evict_ld(evict_ld), .evict_val(evict_val), .full_lookup(full_lookup), .full_proc(full_proc),
      .push_lookup(push_lookup), .push_proc(push_proc), .busy(busy)
`ifdef LLC_BUF_FILL_STATS_EN
      , .fill_count(fill_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0]   cyc;
      logic          pop;
      logic          rdm;
      logic          wr;
      logic [1:0]    way;
      logic [TB-1:0] tag;
      logic [LB-1:0] line;
      logic          dirty;
      logic          ev;
      logic [1:0]    evv;
      logic          pl;
      logic          pp;
   } ev_t;

   ev_t q[$];
   ev_t act_e, exp_e;
   int total = 0;
   int bad = 0;

   logic [TB-1:0] tag_tab   [WAYS] = '{20'h12345, 20'hABCDE, 20'h0F0F0, 20'h55AA5};
   logic [LB-1:0] line_tab  [WAYS] = '{{4{32'hC0DE_0000}}, {4{32'hC0DE_1111}},
                                       {4{32'hC0DE_2222}}, {4{32'hC0DE_3333}}};
   logic          dirty_tab [WAYS] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic add(input int c, input logic pop, input logic rdm, input logic wr,
                      input int way, input logic ev, input logic pu);
      ev_t e;
      e.cyc   = c;
      e.pop   = pop;
      e.rdm   = rdm;
      e.wr    = wr;
      e.way   = wr ? 2'(way) : 2'd0;
      e.tag   = wr ? tag_tab[way] : '0;
      e.line  = wr ? line_tab[way] : '0;
      e.dirty = wr ? dirty_tab[way] : 1'b0;
      e.ev    = ev;
      e.evv   = ev ? 2'd2 : 2'd0;
      e.pl    = pu;
      e.pp    = pu;
      q.push_back(e);
   endtask

   // Look request popped at t: writes t+3..t+6, evict with the last way, push at pc.
   task automatic exp_look(input int t, input int pc);
      add(t, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < WAYS; i++)
         add(t + RD_LAT + 1 + i, 1'b0, 1'b0, 1'b1, i, (i == WAYS - 1), 1'b0);
      add(pc, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic exp_nonlook(input int t);
      add(t, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      add(t + 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
      end
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk(nm, {25'd0, mem_pop, rd_mem_en, buf_wr_en, evict_ld, push_lookup, push_proc, busy}, 32'd0);
      chk({nm, "_data"}, {29'd0, (|buf_line) | (|buf_tag) | buf_dirty, |buf_way, |evict_val}, 32'd0);
   endtask

   always @(negedge clk) begin
      if (mem_pop | rd_mem_en | buf_wr_en | evict_ld | push_lookup | push_proc) begin
         act_e.cyc   = cyc;
         act_e.pop   = mem_pop;
         act_e.rdm   = rd_mem_en;
         act_e.wr    = buf_wr_en;
         act_e.way   = buf_way;
         act_e.tag   = buf_tag;
         act_e.line  = buf_line;
         act_e.dirty = buf_dirty;
         act_e.ev    = evict_ld;
         act_e.evv   = evict_val;
         act_e.pl    = push_lookup;
         act_e.pp    = push_proc;
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected cyc=%0d pop=%b rdm=%b wr=%b way=%0d ev=%b push=%b%b",
                     cyc, mem_pop, rd_mem_en, buf_wr_en, buf_way, evict_ld, push_lookup, push_proc);
         end else begin
            exp_e = q.pop_front();
            if (act_e !== exp_e) begin
               bad++;
               $display("FAIL sb_event got cyc=%0d pop=%b rdm=%b wr=%b way=%0d tag=%h dirty=%b ev=%b evv=%0d push=%b%b line_ok=%b want cyc=%0d pop=%b rdm=%b wr=%b way=%0d tag=%h dirty=%b ev=%b evv=%0d push=%b%b",
                        act_e.cyc, act_e.pop, act_e.rdm, act_e.wr, act_e.way, act_e.tag, act_e.dirty,
                        act_e.ev, act_e.evv, act_e.pl, act_e.pp, (act_e.line === exp_e.line),
                        exp_e.cyc, exp_e.pop, exp_e.rdm, exp_e.wr, exp_e.way, exp_e.tag, exp_e.dirty,
                        exp_e.ev, exp_e.evv, exp_e.pl, exp_e.pp);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      rst_state = 1'b0;
      mem_empty = 1'b0;
      mem_look = 1'b1;
      full_lookup = 1'b0;
      full_proc = 1'b0;
      rd_evict_way = 2'd2;
      rd_state = '1;
      rd_owner = {4'h3, 4'h2, 4'h1, 4'h0};
      rd_sharers = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678};
      rd_hprot = 4'b1010;
      for (int i = 0; i < WAYS; i++) begin
         rd_tag[i*TB +: TB]  = tag_tab[i];
         rd_line[i*LB +: LB] = line_tab[i];
         rd_dirty[i]         = dirty_tab[i];
      end

      while (cyc < 140) begin
         @(posedge clk);
         #1;
         case (cyc)
            1:  chk_idle_outputs("reset_outputs");
            2:  mem_empty = 1'b1;
            3:  rst = 1'b1;
            10: begin exp_look(10, 17); mem_empty = 1'b0; mem_look = 1'b1; end
            11: begin mem_empty = 1'b1; chk("busy_rd_wait", {31'd0, busy}, 32'd1); end
            18: chk("busy_after_push", {31'd0, busy}, 32'd0);
            20: begin exp_nonlook(20); mem_empty = 1'b0; mem_look = 1'b0; end
            21: mem_empty = 1'b1;
            25: begin
               exp_look(25, 40);
               exp_nonlook(41);
               mem_empty = 1'b0;
               mem_look = 1'b1;
               full_proc = 1'b1;
            end
            26: mem_look = 1'b0;
            32: begin
               chk("push_held", {30'd0, push_lookup, push_proc}, 32'd0);
               chk("busy_in_push", {31'd0, busy}, 32'd1);
            end
            40: full_proc = 1'b0;
            42: mem_empty = 1'b1;
            50: begin
               exp_look(50, 57);
               exp_nonlook(58);
               exp_look(60, 67);
               mem_empty = 1'b0;
               mem_look = 1'b1;
            end
            51: mem_look = 1'b0;
            59: mem_look = 1'b1;
            61: mem_empty = 1'b1;
            70: begin
               add(70, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
               add(73, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
               add(74, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
               mem_empty = 1'b0;
               mem_look = 1'b1;
            end
            71: mem_empty = 1'b1;
            74: rst_state = 1'b1;
            75: begin rst_state = 1'b0; chk_idle_outputs("after_rst_state"); end
            80: begin exp_look(80, 87); mem_empty = 1'b0; mem_look = 1'b1; end
            81: mem_empty = 1'b1;
            95: begin
               add(95, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
               mem_empty = 1'b0;
               mem_look = 1'b1;
            end
            96: begin
               mem_empty = 1'b1;
               rst = 1'b0;
               #1;
               chk_idle_outputs("async_rst");
`ifdef LLC_BUF_FILL_STATS_EN
               chk("fill_count_rst", {16'd0, fill_count}, 32'd0);
`endif
            end
            98: rst = 1'b1;
            100, 110, 120: begin exp_look(cyc, cyc + 7); mem_empty = 1'b0; mem_look = 1'b1; end
            101, 111, 121: mem_empty = 1'b1;
`ifdef LLC_BUF_FILL_STATS_EN
            130: chk("fill_count_3", {16'd0, fill_count}, 32'd3);
`endif
            default: ;
         endcase
      end

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL sb_missing pending=%0d next_cyc=%0d", q.size(), q[0].cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
